mc_datapath_p: RTL and testbench

Parametrised multicycle MIPS-subset datapath, the successor to the team's fixed 32-register multicycle datapath. It holds PC, IR, MDR, A, B and ALUOut, the register file, the ALU and all source muxes, and is driven cycle by cycle by the external multicycle controller. Over the previous generation it adds:
- a configurable register-file depth, reset PC and link register;
- a request/ready memory handshake with a global stall;
- conditional PC write with BEQ/BNE selection;
- a correctly ordered jump target.

---
 rtl/mc_pkg.sv | 42 ++++
 rtl/mc_datapath_p_regfile.sv | 35 +++
 rtl/mc_datapath_p.sv | 151 +++++++++++++++
 tb/tb_mc_datapath_p.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants and control encodings
// for the multicycle datapath.
package mc_pkg;

  localparam int DW = 32;
  localparam int LINK_REG_DEF = 31;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MDR = 2'b01,
    WB_PC  = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    SB_B    = 2'b00,
    SB_FOUR = 2'b01,
    SB_IMM  = 2'b10,
    SB_IMM4 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_ALUOUT = 2'b10,
    PC_A      = 2'b11
  } pc_src_e;

endpackage

// File: rtl/mc_datapath_p_regfile.sv
// Register file: NREGS x DW, one sync write port,
// two async read ports, index 0 hardwired to zero.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // No bypass: same-cycle read sees the old value.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mc_datapath_p.sv
// Multicycle MIPS-subset datapath: PC/IR/MDR/A/B/ALUOut,
// regfile, ALU and muxes; memory via req/ready with stall.
module mc_datapath_p
  import mc_pkg::*;
#(
  parameter int           NREGS    = 32,
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  parameter int           LINK_REG = LINK_REG_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_write,
  input  logic          pc_write_cond,
  input  logic          branch_ne,
  input  logic          iord,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          ir_write,
  input  logic [1:0]    reg_dst,
  input  logic [1:0]    wb_src,
  input  logic          reg_write,
  input  logic          alu_src_a,
  input  logic [1:0]    alu_src_b,
  input  logic [2:0]    alu_op,
  input  logic [1:0]    pc_src,
  output logic [5:0]    opc,
  output logic [5:0]    func,
  output logic          zero,
  output logic          stall,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_req,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int AW = $clog2(NREGS);
  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [DW-1:0] pc, ir, mdr, a, b, alu_out;
  logic [DW-1:0] rd1, rd2, imm, src_a, src_b;
  logic [DW-1:0] alu_res, pc_next, wdata;
  logic [4:0]    wsel;
  logic          pc_en;

  assign mem_req   = mem_read | mem_write;
  assign mem_we    = mem_write;
  assign stall     = mem_req & ~mem_ready;
  assign mem_addr  = iord ? alu_out : pc;
  assign mem_wdata = b;
  assign opc       = ir[31:26];
  assign func      = ir[5:0];

  assign imm   = {{16{ir[15]}}, ir[15:0]};
  assign src_a = alu_src_a ? a : pc;

  always_comb begin
    src_b = '0;
    case (alu_src_b)
      SB_B:    src_b = b;
      SB_FOUR: src_b = 32'd4;
      SB_IMM:  src_b = imm;
      SB_IMM4: src_b = {imm[29:0], 2'b00};
      default: src_b = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_SLT: alu_res = {31'd0,
                 $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  always_comb begin
    pc_next = alu_res;
    case (pc_src)
      PC_ALU:    pc_next = alu_res;
      PC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PC_ALUOUT: pc_next = alu_out;
      PC_A:      pc_next = a;
      default:   pc_next = alu_res;
    endcase
  end

  // Undefined selects fall to index 0, i.e. a discarded write.
  always_comb begin
    wsel = '0;
    case (reg_dst)
      DST_RT:   wsel = ir[20:16];
      DST_RD:   wsel = ir[15:11];
      DST_LINK: wsel = LINK_IDX;
      default:  wsel = '0;
    endcase
  end

  always_comb begin
    wdata = '0;
    case (wb_src)
      WB_ALU:  wdata = alu_out;
      WB_MDR:  wdata = mdr;
      WB_PC:   wdata = pc;
      default: wdata = '0;
    endcase
  end

  assign pc_en = ~stall &
    (pc_write | (pc_write_cond & (zero ^ branch_ne)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (!stall) begin
        a       <= rd1;
        b       <= rd2;
        alu_out <= alu_res;
        mdr     <= mem_rdata;
        if (ir_write) ir <= mem_rdata;
      end
      if (pc_en) pc <= pc_next;
    end
  end

  mc_regfile #(.NREGS(NREGS)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_write & ~stall),
    .waddr  (wsel[AW-1:0]),
    .wdata  (wdata),
    .raddr1 (ir[21 +: AW]),
    .raddr2 (ir[16 +: AW]),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p: a 32-reg and an
// 8-reg instance share the same control stimulus.
module tb_mc_datapath_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, pc_write_cond, branch_ne, iord;
  logic        mem_read, mem_write, ir_write, reg_write;
  logic        alu_src_a;
  logic [1:0]  reg_dst, wb_src, alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [5:0]  opc, func, opc8, func8;
  logic        zero, stall, mem_req, mem_we;
  logic        zero8, stall8, mem_req8, mem_we8;
  logic [31:0] mem_addr, mem_wdata, mem_addr8, mem_wdata8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_datapath_p #(
    .NREGS(32), .RESET_PC(32'h0000_0100), .LINK_REG(31)
  ) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .wb_src(wb_src),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .opc(opc), .func(func), .zero(zero), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mc_datapath_p #(
    .NREGS(8), .RESET_PC(32'h0000_0100), .LINK_REG(7)
  ) dut8 (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .wb_src(wb_src),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .opc(opc8), .func(func8), .zero(zero8), .stall(stall8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_req(mem_req8), .mem_we(mem_we8),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    pc_write = 0; pc_write_cond = 0; branch_ne = 0;
    iord = 0; mem_read = 0; mem_write = 0;
    ir_write = 0; reg_write = 0; alu_src_a = 0;
    reg_dst = 0; wb_src = 0; alu_src_b = 0;
    alu_op = 0; pc_src = 0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    clear();
    mem_read = 1; ir_write = 1;
    mem_ready = 1; mem_rdata = v;
    cyc();
    clear();
  endtask

  // lw-style: IR.rt selects dest, MDR supplies data
  task automatic set_reg(input logic [4:0] idx,
                         input logic [31:0] v);
    load_ir({6'h23, 5'd0, idx, 16'h0});
    mem_read = 1; iord = 1; mem_rdata = v;
    cyc();
    clear();
    reg_write = 1; reg_dst = 2'b00; wb_src = 2'b01;
    cyc();
    clear();
  endtask

  // Leaves rf[idx] in B, visible on mem_wdata
  task automatic read_b(input logic [4:0] idx);
    load_ir({6'h00, 5'd0, idx, 16'h0});
    cyc();
  endtask

  task automatic branch(input string tag,
                        input logic [31:0] v,
                        input logic ne,
                        input logic ez);
    load_ir(v);
    alu_src_a = 0; alu_src_b = 2'b11; alu_op = 3'b010;
    cyc();
    clear();
    alu_src_a = 1; alu_src_b = 2'b00; alu_op = 3'b110;
    pc_src = 2'b10; pc_write_cond = 1; branch_ne = ne;
    #1;
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    cyc();
    clear();
    #1;
  endtask

  initial begin
    clear();
    rst = 1; mem_rdata = 0; mem_ready = 0;
    cyc(); cyc();
    rst = 0;
    #1;
    chk("rst_pc", mem_addr, 32'h100);
    chk("rst_opc", 32'(opc), 32'h0);
    chk("rst_func", 32'(func), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    mem_ready = 1;
    #1;
    chk("ready_noreq", 32'(stall), 32'h0);
    read_b(5'd9);
    chk("rst_reg9", mem_wdata, 32'h0);

    // fetch with three wait states
    clear();
    mem_read = 1; ir_write = 1; alu_src_b = 2'b01;
    alu_op = 3'b010; pc_write = 1;
    mem_ready = 0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_stall", 32'(stall), 32'h1);
      chk("wait_pc", mem_addr, 32'h100);
      chk("wait_opc", 32'(opc), 32'h0);
      cyc();
    end
    mem_ready = 1; mem_rdata = 32'h2109_0004;
    #1;
    chk("ready_stall", 32'(stall), 32'h0);
    cyc();
    clear();
    #1;
    chk("fetch_opc", 32'(opc), 32'h08);
    chk("fetch_func", 32'(func), 32'h04);
    chk("fetch_pc", mem_addr, 32'h104);

    // R-type add $10,$8,$9
    set_reg(5'd8, 32'd5);
    set_reg(5'd9, 32'd7);
    load_ir(32'h0109_5020);
    cyc();
    chk("add_b", mem_wdata, 32'd7);
    alu_src_a = 1; alu_src_b = 2'b00; alu_op = 3'b010;
    #1;
    chk("add_zero", 32'(zero), 32'h0);
    cyc();
    clear();
    iord = 1; reg_write = 1; reg_dst = 2'b01;
    wb_src = 2'b00;
    #1;
    chk("add_aluout", mem_addr, 32'd12);
    cyc();
    clear();
    read_b(5'd10);
    chk("add_rd", mem_wdata, 32'd12);
    read_b(5'd8);
    chk("reg8", mem_wdata, 32'd5);
    set_reg(5'd0, 32'h1234);
    read_b(5'd0);
    chk("r0_zero", mem_wdata, 32'h0);

    // branches, PC = 0x104, offset 4 words
    set_reg(5'd11, 32'd3);
    set_reg(5'd12, 32'd3);
    set_reg(5'd13, 32'd4);
    branch("bne_eq", 32'h156C_0004, 1'b1, 1'b1);
    chk("bne_eq_pc", mem_addr, 32'h104);
    branch("bne_ne", 32'h156D_0004, 1'b1, 1'b0);
    chk("bne_ne_pc", mem_addr, 32'h114);
    branch("beq_eq", 32'h116C_0004, 1'b0, 1'b1);
    chk("beq_eq_pc", mem_addr, 32'h124);
    branch("beq_ne", 32'h116D_0004, 1'b0, 1'b0);
    chk("beq_ne_pc", mem_addr, 32'h124);

    // jr-style PC load, then jal
    set_reg(5'd20, 32'hA000_0010);
    load_ir(32'h0280_0000);
    cyc();
    pc_src = 2'b11; pc_write = 1;
    cyc();
    clear();
    #1;
    chk("jr_pc", mem_addr, 32'hA000_0010);
    load_ir(32'h0C00_0040);
    pc_src = 2'b01; pc_write = 1; reg_write = 1;
    reg_dst = 2'b10; wb_src = 2'b10;
    cyc();
    clear();
    #1;
    chk("jal_pc", mem_addr, 32'hA000_0100);
    read_b(5'd31);
    chk("jal_link", mem_wdata, 32'hA000_0010);
    chk("jal_link8", mem_wdata8, 32'hA000_0010);

    // 8-entry file: index 13 aliases register 5
    set_reg(5'd13, 32'h55);
    read_b(5'd5);
    chk("alias8", mem_wdata8, 32'h55);
    chk("noalias32", mem_wdata, 32'h0);

    // SLT -1 < 1
    set_reg(5'd1, 32'hFFFF_FFFF);
    set_reg(5'd2, 32'd1);
    load_ir(32'h0022_002A);
    cyc();
    alu_src_a = 1; alu_src_b = 2'b00; alu_op = 3'b111;
    #1;
    chk("slt_zero", 32'(zero), 32'h0);
    chk("slt_zero8", 32'(zero8), 32'h0);
    cyc();
    clear();
    iord = 1;
    #1;
    chk("slt_res", mem_addr, 32'd1);
    chk("slt_res8", mem_addr8, 32'd1);
    alu_src_a = 1; alu_op = 3'b011;
    #1;
    chk("undef_op", 32'(zero), 32'h1);

    // reset wins over pc_write
    clear();
    pc_src = 2'b11; pc_write = 1; rst = 1;
    cyc();
    rst = 0;
    clear();
    #1;
    chk("rst_prio", mem_addr, 32'h100);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
